// File: rtl/parking_entry_gate.sv
// Entry-lane barrier controller: debounces arrive/pass sensors, admits or denies by vacancy, pulses once per entered car.
// Optional GATE_STATS_EN adds saturating admitted/denied/timeout counters.
module parking_entry_gate #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int OPEN_TIMEOUT    = 50,
    parameter int DENY_CYCLES     = 10,
    parameter int CNT_W           = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arrive_sensor,
    input  logic        pass_sensor,
    input  logic        uni_badge,
    input  logic        space_avail_uni,
    input  logic        space_avail_free,
    output logic        gate_open,
    output logic        deny_light,
    output logic        entered_car,
    output logic        entered_car_uni_is,
    output logic        busy
`ifdef GATE_STATS_EN
    ,
    output logic [15:0] admitted_count,
    output logic [15:0] denied_count,
    output logic [15:0] timeout_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECIDE,
        S_OPEN,
        S_WAIT_CLEAR,
        S_DENY
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(OPEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] DENY_LAST = CNT_W'(DENY_CYCLES - 1);

    // Index 0 = arrive sensor, index 1 = pass sensor.
    logic [1:0]       w_raw;
    logic [1:0]       r_db;
    logic [CNT_W-1:0] r_db_cnt [2];
    logic             w_arrive_db;
    logic             w_pass_db;

    assign w_raw       = {pass_sensor, arrive_sensor};
    assign w_arrive_db = r_db[0];
    assign w_pass_db   = r_db[1];

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values, avoiding order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_db <= '0;
            for (int i = 0; i < 2; i++) r_db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_raw[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= w_raw[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_class_uni;
    logic             w_next_class_uni;
    logic             r_arrive_prev;
    logic             r_armed;
    logic             w_entered;
    logic             w_timeout;
    logic             w_deny_entry;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_next_state     = r_state;
        w_next_cnt       = r_cnt;
        w_next_class_uni = r_class_uni;
        w_entered        = 1'b0;
        w_timeout        = 1'b0;
        w_deny_entry     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arrive_db && !r_arrive_prev && r_armed) w_next_state = S_DECIDE;
            end
            S_DECIDE: begin
                w_next_cnt = '0;
                if (uni_badge && space_avail_uni) begin
                    w_next_state     = S_OPEN;
                    w_next_class_uni = 1'b1;
                end else if (space_avail_free) begin
                    w_next_state     = S_OPEN;
                    w_next_class_uni = 1'b0;
                end else begin
                    w_next_state = S_DENY;
                    w_deny_entry = 1'b1;
                end
            end
            S_OPEN: begin
                if (w_pass_db) begin
                    w_next_state = S_WAIT_CLEAR;
                end else if (r_cnt == TO_LAST) begin
                    w_next_state = S_IDLE;
                    w_timeout    = 1'b1;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            S_WAIT_CLEAR: begin
                if (!w_pass_db) begin
                    w_next_state = S_IDLE;
                    w_entered    = 1'b1;
                end
            end
            S_DENY: begin
                if (r_cnt == DENY_LAST) begin
                    if (!w_arrive_db) w_next_state = S_IDLE;
                end else begin
                    w_next_cnt = r_cnt + CNT_ONE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // A car sitting on the loop at reset must leave (raw and debounced low) before arrivals are honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_class_uni        <= 1'b0;
            r_arrive_prev      <= 1'b0;
            r_armed            <= 1'b0;
            gate_open          <= 1'b0;
            deny_light         <= 1'b0;
            entered_car        <= 1'b0;
            entered_car_uni_is <= 1'b0;
            busy               <= 1'b0;
        end else begin
            r_state            <= w_next_state;
            r_cnt              <= w_next_cnt;
            r_class_uni        <= w_next_class_uni;
            r_arrive_prev      <= w_arrive_db;
            r_armed            <= r_armed || (!arrive_sensor && !w_arrive_db);
            gate_open          <= (w_next_state == S_OPEN) || (w_next_state == S_WAIT_CLEAR);
            deny_light         <= (w_next_state == S_DENY);
            entered_car        <= w_entered;
            entered_car_uni_is <= w_entered && r_class_uni;
            busy               <= (w_next_state != S_IDLE);
        end
    end

`ifdef GATE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            admitted_count <= '0;
            denied_count   <= '0;
            timeout_count  <= '0;
        end else begin
            if (w_entered && admitted_count != 16'hFFFF) admitted_count <= admitted_count + 16'd1;
            if (w_deny_entry && denied_count != 16'hFFFF) denied_count <= denied_count + 16'd1;
            if (w_timeout && timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parking_entry_gate.sv
// Directed bench for parking_entry_gate (default parameters: debounce 4, timeout 50, deny 10).
module tb_parking_entry_gate;

    logic clk = 1'b0;
    logic rst;
    logic arrive_sensor;
    logic pass_sensor;
    logic uni_badge;
    logic space_avail_uni;
    logic space_avail_free;
    logic gate_open;
    logic deny_light;
    logic entered_car;
    logic entered_car_uni_is;
    logic busy;
`ifdef GATE_STATS_EN
    logic [15:0] admitted_count;
    logic [15:0] denied_count;
    logic [15:0] timeout_count;
`endif

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    parking_entry_gate dut (
        .clk                (clk),
        .rst                (rst),
        .arrive_sensor      (arrive_sensor),
        .pass_sensor        (pass_sensor),
        .uni_badge          (uni_badge),
        .space_avail_uni    (space_avail_uni),
        .space_avail_free   (space_avail_free),
        .gate_open          (gate_open),
        .deny_light         (deny_light),
        .entered_car        (entered_car),
        .entered_car_uni_is (entered_car_uni_is),
        .busy               (busy)
`ifdef GATE_STATS_EN
        ,
        .admitted_count     (admitted_count),
        .denied_count       (denied_count),
        .timeout_count      (timeout_count)
`endif
    );

    always #5 clk = ~clk;

    // Each entered_car pulse spans exactly one negedge.
    always @(negedge clk) if (entered_car) pulse_cnt++;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; arrive_sensor = 1'b0; pass_sensor = 1'b0;
        uni_badge = 1'b0; space_avail_uni = 1'b0; space_avail_free = 1'b0;
        step(3);
        total++;
        if ({gate_open, deny_light, entered_car, entered_car_uni_is, busy} !== 5'b0) begin
            bad++; $display("FAIL reset_outputs: got %b want 00000", {gate_open, deny_light, entered_car, entered_car_uni_is, busy});
        end
`ifdef GATE_STATS_EN
        total++;
        if ({admitted_count, denied_count, timeout_count} !== 48'd0) begin
            bad++; $display("FAIL reset_stats: got %h want 0", {admitted_count, denied_count, timeout_count});
        end
`endif
        rst = 1'b0;
        step(1);
    endtask

    // Full passage; flags optionally withdrawn once the gate is open to show the admission stands.
    task automatic run_passage(input string name, input logic badge, input logic avail_uni, input logic avail_free,
                               input logic drop_flags, input logic want_uni);
        int p0;
        p0 = pulse_cnt;
        uni_badge = badge; space_avail_uni = avail_uni; space_avail_free = avail_free;
        arrive_sensor = 1'b1;
        step(5);
        total++;
        if ({gate_open, busy} !== 2'b01) begin
            bad++; $display("FAIL %s_pre_open: got gate,busy=%b want 01", name, {gate_open, busy});
        end
        step(1);
        total++;
        if (gate_open !== 1'b1) begin
            bad++; $display("FAIL %s_open_latency: got gate=%b want 1", name, gate_open);
        end
        if (drop_flags) begin
            space_avail_uni = 1'b0; space_avail_free = 1'b0;
        end
        step(3);
        arrive_sensor = 1'b0; pass_sensor = 1'b1;
        step(5);
        pass_sensor = 1'b0;
        step(4);
        total++;
        if ({gate_open, entered_car, busy} !== 3'b101) begin
            bad++; $display("FAIL %s_wait_clear: got gate,entered,busy=%b want 101", name, {gate_open, entered_car, busy});
        end
        step(1);
        total++;
        if ({gate_open, entered_car, entered_car_uni_is} !== {2'b01, want_uni}) begin
            bad++; $display("FAIL %s_pulse: got gate,entered,uni=%b want %b", name,
                            {gate_open, entered_car, entered_car_uni_is}, {2'b01, want_uni});
        end
        step(1);
        total++;
        if ({entered_car, entered_car_uni_is, busy} !== 3'b000) begin
            bad++; $display("FAIL %s_after_pulse: got entered,uni,busy=%b want 000", name, {entered_car, entered_car_uni_is, busy});
        end
        total++;
        if (pulse_cnt !== p0 + 1) begin
            bad++; $display("FAIL %s_pulse_count: got %0d want %0d", name, pulse_cnt - p0, 1);
        end
        step(6);
    endtask

    task automatic test_uni_admit();
        run_passage("uni", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_overflow();
        run_passage("overflow", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_deny_long();
        int p0;
        p0 = pulse_cnt;
        uni_badge = 1'b0; space_avail_uni = 1'b0; space_avail_free = 1'b0;
        arrive_sensor = 1'b1;
        step(5);
        total++;
        if (deny_light !== 1'b0) begin
            bad++; $display("FAIL deny_early: got deny=%b want 0", deny_light);
        end
        step(1);
        total++;
        if ({deny_light, gate_open} !== 2'b10) begin
            bad++; $display("FAIL deny_rise: got deny,gate=%b want 10", {deny_light, gate_open});
        end
        pass_sensor = 1'b1;
        step(6);
        pass_sensor = 1'b0;
        step(18);
        total++;
        if ({deny_light, gate_open, busy} !== 3'b101) begin
            bad++; $display("FAIL deny_held: got deny,gate,busy=%b want 101", {deny_light, gate_open, busy});
        end
        arrive_sensor = 1'b0;
        step(4);
        total++;
        if (deny_light !== 1'b1) begin
            bad++; $display("FAIL deny_until_clear: got deny=%b want 1", deny_light);
        end
        step(1);
        total++;
        if ({deny_light, busy} !== 2'b00) begin
            bad++; $display("FAIL deny_release: got deny,busy=%b want 00", {deny_light, busy});
        end
        total++;
        if (pulse_cnt !== p0) begin
            bad++; $display("FAIL deny_no_pulse: got %0d pulses want 0", pulse_cnt - p0);
        end
        step(4);
    endtask

    task automatic test_deny_min();
        arrive_sensor = 1'b1;
        step(5);
        arrive_sensor = 1'b0;
        step(1);
        total++;
        if (deny_light !== 1'b1) begin
            bad++; $display("FAIL deny_min_rise: got deny=%b want 1", deny_light);
        end
        step(9);
        total++;
        if (deny_light !== 1'b1) begin
            bad++; $display("FAIL deny_min_hold10: got deny=%b want 1", deny_light);
        end
        step(1);
        total++;
        if (deny_light !== 1'b0) begin
            bad++; $display("FAIL deny_min_release: got deny=%b want 0", deny_light);
        end
        step(4);
    endtask

    task automatic test_timeout();
        int p0;
        p0 = pulse_cnt;
        uni_badge = 1'b0; space_avail_uni = 1'b1; space_avail_free = 1'b1;
        arrive_sensor = 1'b1;
        step(6);
        arrive_sensor = 1'b0;
        step(49);
        total++;
        if (gate_open !== 1'b1) begin
            bad++; $display("FAIL timeout_open50: got gate=%b want 1", gate_open);
        end
        step(1);
        total++;
        if ({gate_open, busy} !== 2'b00) begin
            bad++; $display("FAIL timeout_close: got gate,busy=%b want 00", {gate_open, busy});
        end
        total++;
        if (pulse_cnt !== p0) begin
            bad++; $display("FAIL timeout_no_pulse: got %0d pulses want 0", pulse_cnt - p0);
        end
        step(4);
    endtask

    task automatic test_pass_in_idle();
        int p0;
        p0 = pulse_cnt;
        pass_sensor = 1'b1;
        step(8);
        pass_sensor = 1'b0;
        step(6);
        total++;
        if ({gate_open, busy} !== 2'b00 || pulse_cnt !== p0) begin
            bad++; $display("FAIL idle_pass_ignored: got gate,busy=%b pulses=%0d want 00 pulses=0", {gate_open, busy}, pulse_cnt - p0);
        end
    endtask

    task automatic test_glitches();
        for (int len = 1; len <= 3; len++) begin
            arrive_sensor = 1'b1;
            step(len);
            arrive_sensor = 1'b0;
            step(2);
            total++;
            if ({gate_open, deny_light, busy} !== 3'b000) begin
                bad++; $display("FAIL glitch_len%0d: got gate,deny,busy=%b want 000", len, {gate_open, deny_light, busy});
            end
        end
        step(4);
        total++;
        if ({gate_open, deny_light, entered_car, busy} !== 4'b0000) begin
            bad++; $display("FAIL glitch_settle: got %b want 0000", {gate_open, deny_light, entered_car, busy});
        end
    endtask

    task automatic test_stats();
`ifdef GATE_STATS_EN
        total++;
        if ({admitted_count, denied_count, timeout_count} !== {16'd2, 16'd2, 16'd1}) begin
            bad++; $display("FAIL stats: got adm=%0d den=%0d to=%0d want 2 2 1", admitted_count, denied_count, timeout_count);
        end
`endif
    endtask

    task automatic test_reset_mid_pass();
        int p0;
        p0 = pulse_cnt;
        uni_badge = 1'b1; space_avail_uni = 1'b1; space_avail_free = 1'b0;
        arrive_sensor = 1'b1;
        step(6);
        arrive_sensor = 1'b0; pass_sensor = 1'b1;
        step(8);
        total++;
        if ({gate_open, busy} !== 2'b11) begin
            bad++; $display("FAIL rstmid_in_wait: got gate,busy=%b want 11", {gate_open, busy});
        end
        rst = 1'b1;
        step(1);
        total++;
        if ({gate_open, busy, entered_car} !== 3'b000) begin
            bad++; $display("FAIL rstmid_cleared: got gate,busy,entered=%b want 000", {gate_open, busy, entered_car});
        end
        pass_sensor = 1'b0;
        step(1);
        rst = 1'b0;
        step(8);
        total++;
        if (pulse_cnt !== p0) begin
            bad++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", pulse_cnt - p0);
        end
        run_passage("post_reset", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef GATE_STATS_EN
        total++;
        if ({admitted_count, denied_count, timeout_count} !== {16'd1, 16'd0, 16'd0}) begin
            bad++; $display("FAIL stats_after_rst: got adm=%0d den=%0d to=%0d want 1 0 0", admitted_count, denied_count, timeout_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_uni_admit();
        test_overflow();
        test_deny_long();
        test_deny_min();
        test_timeout();
        test_pass_in_idle();
        test_glitches();
        test_stats();
        test_reset_mid_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_entry_gate.md
Name: parking_entry_gate

Overview:
- Entry-lane gate controller directly upstream of the parking management block.
- Debounces the lane's arrival and pass-through sensors and reads the car's badge type.
- Checks the vacancy flags fed back from the management block, then either opens the barrier or lights the deny lamp.
- Emits exactly one single-cycle entered_car / entered_car_uni_is pulse per car that actually passes the barrier.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical raw samples required before a debounced sensor changes value (min 1).
- OPEN_TIMEOUT, 50, cycles the gate stays open waiting for pass_sensor before aborting.
- DENY_CYCLES, 10, minimum cycles deny_light is held.
- CNT_W, 8, width of the internal debounce/timeout counters; must hold max(DEBOUNCE_CYCLES, OPEN_TIMEOUT, DENY_CYCLES).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- arrive_sensor  input  1  raw loop sensor, car waiting at barrier
- pass_sensor  input  1  raw beam sensor, car under/through barrier
- uni_badge  input  1  badge reader: 1 = university car (valid while arrive_sensor high)
- space_avail_uni  input  1  from management block: university space vacant
- space_avail_free  input  1  from management block: free space vacant
- gate_open  output  1  barrier open command
- deny_light  output  1  red lamp, entry refused
- entered_car  output  1  one-cycle pulse, car has entered
- entered_car_uni_is  output  1  qualifies entered_car: 1 = car took a university space
- busy  output  1  high in any state other than IDLE

Behaviour:
- Synchronous active-high reset, single clock clk. All outputs registered.
- Reset values: every output 0, state IDLE, debounced sensors 0, all counters 0.
- Debounce, per sensor:
  - The counter increments while raw != debounced value and clears when raw == debounced value.
  - The debounced value flips on the edge that samples the DEBOUNCE_CYCLES-th consecutive differing raw value.
- State machine:
  - IDLE: on a rising edge of debounced arrive, go to DECIDE. A car already present at reset must fully clear (arrive_db low) before it can trigger.
  - DECIDE (1 cycle): latch uni_badge and the availability flags.
    - Badge 1 and space_avail_uni = 1: OPEN with granted class uni.
    - Otherwise, space_avail_free = 1: OPEN with granted class free. A university car overflows into free space.
    - Otherwise: DENY.
  - OPEN: gate_open = 1. Counter counts cycles in OPEN.
    - Debounced pass high: go to WAIT_CLEAR.
    - Counter reaches OPEN_TIMEOUT with no pass: go to IDLE, no pulse (aborted entry).
  - WAIT_CLEAR: gate_open = 1. When debounced pass falls:
    - In the same edge, register entered_car = 1 and entered_car_uni_is = latched class.
    - Go to IDLE; gate_open drops in the same cycle the pulse is visible.
  - DENY: deny_light = 1 for at least DENY_CYCLES cycles, then remains until debounced arrive is low, then go to IDLE.
- Latency: gate_open rises DEBOUNCE_CYCLES+2 edges after the first high raw arrive sample.
- entered_car_uni_is is 0 whenever entered_car is 0.
- Availability flags are sampled only in DECIDE. Changes during OPEN/WAIT_CLEAR are ignored; the admission stands.
- If pass_sensor is seen high in IDLE or DENY (tailgater or reversing car), it is ignored and no pulse is generated.
- If arrive drops during OPEN, the gate stays open until pass or timeout.
- rst asserted in any state: the next edge returns to IDLE with outputs 0 and no pulse. A car mid-passage is not counted.

Optional Feature:
GATE_STATS_EN
- Defined: adds three 16-bit outputs admitted_count, denied_count and timeout_count.
  - They increment on the entered_car pulse, on entry to DENY, and on OPEN timeout respectively.
  - They saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, uni_badge=1, space_avail_uni=1, arrive high steady, then pass high 5 cycles, then low -> gate_open rises 6 edges after arrive. One entered_car=1 with entered_car_uni_is=1 after pass_db falls. gate_open=0 at the same time.
- uni_badge=1, space_avail_uni=0, space_avail_free=1, full passage -> entered_car=1, entered_car_uni_is=0.
- space_avail_uni=0, space_avail_free=0, arrive held 30 cycles -> deny_light high from DECIDE+1 until arrive_db low (>=10 cycles). No gate_open, no entered_car.
- Admit, never assert pass -> gate_open high exactly 50 cycles, then IDLE. No pulse; timeout_count=1 with GATE_STATS_EN.
- arrive glitches of 1-3 cycles separated by lows, DEBOUNCE_CYCLES=4 -> state stays IDLE, all outputs 0.
- rst asserted 3 cycles into WAIT_CLEAR -> next cycle gate_open=0, busy=0. entered_car never pulses; a subsequent car is admitted normally.
